ex_issue: RTL and testbench
===========================

Name: ex_issue

Overview:
- Execute-issue stage directly upstream of the ALU.
- Decodes a fetched RV32I instruction plus its register-file read data into ALU operands A/B and the 4-bit ALUop, together with writeback and branch side information.
- Holds the result in a 2-entry skid buffer with valid/ready handshakes on both sides, so the execute stage can stall without combinational ready paths back to decode.

Parameters:
- DATA_WIDTH, 32, operand and PC width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- in_rs1_data  in  32  rs1 read value.
- in_rs2_data  in  32  rs2 read value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ALU/execute consumes the head entry.
- out_alu_a  out  32  ALU operand A.
- out_alu_b  out  32  ALU operand B.
- out_alu_op  out  4  ALUop.
- out_rd  out  5  destination register.
- out_rf_wen  out  1  writeback enable.
- out_is_branch  out  1  conditional branch.
- out_br_funct3  out  3  branch condition (inst[14:12]).
- out_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst_n=0, asynchronous): both entries invalid; out_valid=0, in_ready=1; all payload outputs 0.
- ALUop encoding (shared package): AND 0000, OR 0001, NOR 0011, ADD 0010, SUB 1010, SLT 1011, SL 0100, SRL 0110, SRA 0111, XOR 0101, SLTU 1111.
- Decode is combinational on input fields, then registered into the buffer:
  - OP (0110011): A=rs1, B=rs2.
    - f3 000: funct7[5] ? SUB : ADD.
    - 001 SL; 010 SLT; 011 SLTU; 100 XOR.
    - 101: funct7[5] ? SRA : SRL.
    - 110 OR; 111 AND.
  - OP-IMM (0010011): B = sign-extended I-immediate; same mapping, but f3 000 is always ADD.
  - Shifts (OP and OP-IMM): B = {27'b0, shamt}. shamt is rs2[4:0] for OP and inst[24:20] for OP-IMM. The ALU shifts by the full B, so masking here is mandatory.
  - LUI: A=0, B={inst[31:12],12'b0}, ADD.
  - AUIPC: A=pc, B=U-immediate, ADD.
  - LOAD: A=rs1, B=I-immediate, ADD.
  - STORE: A=rs1, B=S-immediate, ADD.
  - BRANCH: A=rs1, B=rs2.
    - BEQ/BNE: SUB; execute decides on Zero.
    - BLT/BGE: SLT; execute decides on Result[0].
    - BLTU/BGEU: SLTU; execute decides on Result[0].
    - out_is_branch=1.
  - JAL/JALR: A=pc, B=4, ADD (link value).
  - Any other opcode: A=0, B=0, ADD, out_illegal=1, out_rf_wen=0.
  - out_rf_wen=1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR, forced 0 when rd==0.
  - out_rd = inst[11:7] when out_rf_wen=1, else 0.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Payload is held stable while out_valid & !out_ready.
- Buffer: one main register feeds the outputs; one skid register.
  - Accept while main is empty or draining: write main.
  - Accept while main is held: write skid, and in_ready falls to 0 next cycle.
  - Main drains while skid is full: skid moves to main, and in_ready returns to 1 next cycle.
  - Throughput is 1/cycle with out_ready held at 1. Latency is 1 cycle from input accept to out_valid.
  - Order is strictly FIFO.
- flush=1: both entries invalidated next edge. flush has priority over a same-cycle accept, which is dropped. in_ready=1 the cycle after.
- Simultaneous accept and drain with one entry held: the new entry lands in main, and skid is unused.

Decomposition:
- Package ex_pkg:
  - ALUop localparams.
  - Opcode constants: OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR.
  - Payload width constant.
  - Immediate-extraction functions.
- Sub-module skid_buf (generic 2-entry valid/ready buffer, parameterised by payload width). Decode logic stays in ex_issue.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, A=5, B=7, op=0010, rd=3, rf_wen=1.
- sub with the same operands (0x402081B3) -> op=1010. sll with rs2=0x00000021 -> op=0100, B=0x00000001.
- srai x5,x6,3 (0x40335293) -> op=0111, B=3. lui x1,0x12345 (0x123450B7) -> A=0, B=0x12345000, op=0010.
- beq x1,x2,+8 (0x00208463) -> op=1010, is_branch=1, br_funct3=000, rf_wen=0, rd=0.
- Backpressure: out_ready=0, push three entries -> first two accepted, in_ready=0 after the second. Release out_ready -> entries emerge in order, one per cycle.
- Flush or rst_n=0 with two entries held -> out_valid=0 immediately for reset, next edge for flush; in_ready=1; all-zero instruction word -> out_illegal=1.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute-issue stage.
// ALUop encodings, RV32I opcodes, payload bundle, immediate helpers.
package ex_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SL   = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;
  } ex_payload_t;

  localparam int PAYLOAD_W = $bits(ex_payload_t);

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [3:0] alu_f3(
    input logic [2:0] f3,
    input logic       f7b,
    input logic       is_reg
  );
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = (is_reg && f7b) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_issue_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// Main register drives the outputs; skid absorbs one entry under stall.
module skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         drain, acc;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drain    = main_v_q & out_ready;
    acc      = in_valid & rdy_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (drain) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else begin
      if (drain) main_v_d = 1'b0;
      if (acc) begin
        if (!main_v_q || drain) begin
          main_v_d = 1'b1;
          main_d   = in_data;
        end else begin
          skid_v_d = 1'b1;
          skid_d   = in_data;
        end
      end
    end
    rdy_d = !skid_v_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

endmodule

// File: rtl/ex_issue.sv
// Execute-issue stage: RV32I decode into ALU operands/ALUop,
// buffered through a 2-entry skid buffer toward the ALU.
module ex_issue
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_a,
  output logic [DATA_WIDTH-1:0] out_alu_b,
  output logic [3:0]            out_alu_op,
  output logic [4:0]            out_rd,
  output logic                  out_rf_wen,
  output logic                  out_is_branch,
  output logic [2:0]            out_br_funct3,
  output logic                  out_illegal
);

  ex_payload_t dec, head;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        f7b;
  logic        wen;
  logic        shift;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign rd    = in_inst[11:7];
  assign f7b   = in_inst[30];
  assign shift = (f3 == 3'b001) || (f3 == 3'b101);

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    wen        = 1'b0;
    unique case (1'b1)
      opc == OP: begin
        dec.alu_a  = in_rs1_data;
        dec.alu_b  = shift ? {27'b0, in_rs2_data[4:0]} : in_rs2_data;
        dec.alu_op = alu_f3(f3, f7b, 1'b1);
        wen        = 1'b1;
      end
      opc == OP_IMM: begin
        dec.alu_a  = in_rs1_data;
        dec.alu_b  = shift ? {27'b0, in_inst[24:20]} : imm_i(in_inst);
        dec.alu_op = alu_f3(f3, f7b, 1'b0);
        wen        = 1'b1;
      end
      opc == LUI: begin
        dec.alu_b = imm_u(in_inst);
        wen       = 1'b1;
      end
      opc == AUIPC: begin
        dec.alu_a = in_pc;
        dec.alu_b = imm_u(in_inst);
        wen       = 1'b1;
      end
      opc == LOAD: begin
        dec.alu_a = in_rs1_data;
        dec.alu_b = imm_i(in_inst);
        wen       = 1'b1;
      end
      opc == STORE: begin
        dec.alu_a = in_rs1_data;
        dec.alu_b = imm_s(in_inst);
      end
      opc == BRANCH: begin
        dec.alu_a     = in_rs1_data;
        dec.alu_b     = in_rs2_data;
        dec.is_branch = 1'b1;
        dec.br_funct3 = f3;
        unique case (f3[2:1])
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.alu_op = ALU_SUB;
        endcase
      end
      (opc == JAL) || (opc == JALR): begin
        dec.alu_a = in_pc;
        dec.alu_b = 32'd4;
        wen       = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // x0 is never written, so suppress both enable and index
    dec.rf_wen = wen && (rd != 5'd0);
    dec.rd     = dec.rf_wen ? rd : 5'd0;
  end

  skid_buf #(
    .W(PAYLOAD_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign out_alu_a     = head.alu_a;
  assign out_alu_b     = head.alu_b;
  assign out_alu_op    = head.alu_op;
  assign out_rd        = head.rd;
  assign out_rf_wen    = head.rf_wen;
  assign out_is_branch = head.is_branch;
  assign out_br_funct3 = head.br_funct3;
  assign out_illegal   = head.illegal;

endmodule

// File: tb/tb_ex_issue.sv
// Directed bench for ex_issue: decode vectors, backpressure,
// flush and asynchronous reset with buffered entries.
module tb_ex_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_rf_wen;
  logic        out_is_branch;
  logic [2:0]  out_br_funct3;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  ex_issue #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_a    (out_alu_a),
    .out_alu_b    (out_alu_b),
    .out_alu_op   (out_alu_op),
    .out_rd       (out_rd),
    .out_rf_wen   (out_rf_wen),
    .out_is_branch(out_is_branch),
    .out_br_funct3(out_br_funct3),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op,
                         input logic [4:0] rd, input logic wen,
                         input logic br, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".a"}, out_alu_a, a);
    chk({tag, ".b"}, out_alu_b, b);
    chk({tag, ".op"}, 32'(out_alu_op), 32'(op));
    chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
    chk({tag, ".wen"}, 32'(out_rf_wen), 32'(wen));
    chk({tag, ".br"}, 32'(out_is_branch), 32'(br));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2);
    in_valid    = 1'b1;
    in_inst     = inst;
    in_pc       = pc;
    in_rs1_data = r1;
    in_rs2_data = r2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_inst     = '0;
    in_pc       = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready   = 1'b1;
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.a", out_alu_a, 32'd0);
    chk("rst.b", out_alu_b, 32'd0);
    chk("rst.op", 32'(out_alu_op), 32'd0);
    chk("rst.ill", 32'(out_illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // decode vectors, back to back with out_ready=1
    push(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk_out("add", 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 1'b0, 1'b0);
    push(32'h402081B3, 32'h0, 32'd5, 32'd7);
    chk_out("sub", 32'd5, 32'd7, 4'b1010, 5'd3, 1'b1, 1'b0, 1'b0);
    push(32'h002091B3, 32'h0, 32'd5, 32'h21);
    chk_out("sll", 32'd5, 32'd1, 4'b0100, 5'd3, 1'b1, 1'b0, 1'b0);
    push(32'h40335293, 32'h0, 32'h100, 32'hDEAD_BEEF);
    chk_out("srai", 32'h100, 32'd3, 4'b0111, 5'd5, 1'b1, 1'b0, 1'b0);
    push(32'h123450B7, 32'h0, 32'h5555_5555, 32'h1);
    chk_out("lui", 32'd0, 32'h12345000, 4'b0010, 5'd1, 1'b1, 1'b0, 1'b0);
    push(32'h00208463, 32'h0, 32'd9, 32'd11);
    chk_out("beq", 32'd9, 32'd11, 4'b1010, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("beq.f3", 32'(out_br_funct3), 32'd0);
    push(32'h0020C463, 32'h0, 32'd9, 32'd11);
    chk_out("blt", 32'd9, 32'd11, 4'b1011, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("blt.f3", 32'(out_br_funct3), 32'd4);
    push(32'hFFF00093, 32'h0, 32'd0, 32'd0);
    chk_out("addi_m1", 32'd0, 32'hFFFF_FFFF, 4'b0010, 5'd1, 1'b1, 1'b0,
            1'b0);
    push(32'h40000093, 32'h0, 32'd3, 32'd0);
    chk_out("addi_f7", 32'd3, 32'h400, 4'b0010, 5'd1, 1'b1, 1'b0, 1'b0);
    push(32'h00208033, 32'h0, 32'd5, 32'd7);
    chk_out("add_x0", 32'd5, 32'd7, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0);
    push(32'h008000EF, 32'h1000, 32'd1, 32'd2);
    chk_out("jal", 32'h1000, 32'd4, 4'b0010, 5'd1, 1'b1, 1'b0, 1'b0);
    push(32'h0020A223, 32'h0, 32'h200, 32'd2);
    chk_out("sw", 32'h200, 32'd4, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0);
    push(32'h00000000, 32'h40, 32'd1, 32'd2);
    chk_out("illegal", 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // backpressure: two accepted, third blocked, FIFO drain
    out_ready = 1'b0;
    push(32'h002081B3, 32'h0, 32'd1, 32'd0);
    chk("bp1.in_ready", 32'(in_ready), 32'd1);
    chk("bp1.a", out_alu_a, 32'd1);
    push(32'h002081B3, 32'h0, 32'd2, 32'd0);
    chk("bp2.in_ready", 32'(in_ready), 32'd0);
    chk("bp2.a", out_alu_a, 32'd1);
    push(32'h002081B3, 32'h0, 32'd3, 32'd0);
    chk("bp3.in_ready", 32'(in_ready), 32'd0);
    chk("bp3.hold", out_alu_a, 32'd1);
    chk("bp3.valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("bp4.a", out_alu_a, 32'd2);
    chk("bp4.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp5.a", out_alu_a, 32'd3);
    chk("bp5.valid", 32'(out_valid), 32'd1);
    tick();
    chk("bp6.valid", 32'(out_valid), 32'd0);

    // flush with two held entries; same-cycle accept is dropped
    out_ready = 1'b0;
    push(32'h002081B3, 32'h0, 32'd7, 32'd0);
    push(32'h002081B3, 32'h0, 32'd8, 32'd0);
    chk("fl.pre_ready", 32'(in_ready), 32'd0);
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_rs1_data = 32'd9;
    #3;
    chk("fl.before_edge", 32'(out_valid), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fl.dropped", 32'(out_valid), 32'd0);

    // asynchronous reset with two held entries
    out_ready = 1'b0;
    push(32'h002081B3, 32'h0, 32'd4, 32'd0);
    push(32'h002081B3, 32'h0, 32'd5, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    chk("ar.a", out_alu_a, 32'd0);
    chk("ar.rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
